// File: rtl/serial_deserializer8_pkg.sv
// rtl/serial_deserializer8_pkg.sv - shared types, constants and parity helper for the deserializer
package serial_deserializer8_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  // Parity helper input width; narrower frames are zero-padded, which leaves parity unchanged.
  localparam int PARITY_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Even-parity bit: 1 when the vector holds an odd number of ones.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_deserializer8_sipo_shift_reg.sv
// rtl/serial_deserializer8_sipo_shift_reg.sv - indexed bit-insert register with frame bit count
//   clk       : clock
//   rst       : synchronous active-high reset
//   load_en_i : store bit_i at index count_o and advance the count
//   bit_i     : serial bit to store
//   data_o    : collected bits, first bit at data_o[0]
//   count_o   : index of the next bit, wraps to 0 after WIDTH-1
module sipo_shift_reg
  import serial_deserializer8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en_i,
  input  logic             bit_i,
  output logic [0:WIDTH-1] data_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [0:WIDTH-1] data_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load_en_i) begin
      data_q[count_q] <= bit_i;
      // Each frame restarts at index 0; older bits are simply overwritten.
      count_q <= (count_q == LAST_IDX) ? '0 : count_q + CW'(1);
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/serial_deserializer8.sv
// rtl/serial_deserializer8.sv - serial-in parallel-out byte assembler with holding register
//   clk, rst    : clock, synchronous active-high reset
//   sin         : serial data bit, sampled when sin_valid=1
//   q, q_valid  : held frame (first bit in q[0]) and its valid flag
//   q_ready     : downstream consumes q when q_valid && q_ready
//   parity_err  : one-cycle pulse when a frame is discarded for bad parity
//   overrun     : sticky flag for a good frame dropped while holding was full
//   overrun_clr : clears overrun
module serial_deserializer8
  import serial_deserializer8_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [0:WIDTH-1] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             parity_err,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [0:WIDTH-1]            shift_data;
  logic [CW-1:0]               count;
  logic                        shift_load;
  logic [0:WIDTH-1]            frame;
  logic [PARITY_MAX_WIDTH-1:0] frame_pad;
  logic                        frame_done;
  logic                        frame_good;
  logic                        hold_free;

  logic [0:WIDTH-1] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;

  sipo_shift_reg #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load_en_i (shift_load),
    .bit_i     (sin),
    .data_o    (shift_data),
    .count_o   (count)
  );

  // The frame completes on the edge that samples its final bit, so without a
  // parity phase the bit being stored this cycle is merged in combinationally.
  always_comb begin
    frame = shift_data;
    if (state_q != PARITY) begin
      frame[count] = sin;
    end
    frame_pad = '0;
    frame_pad[WIDTH-1:0] = frame;
  end

  always_comb begin
    state_d    = state_q;
    shift_load = 1'b0;
    frame_done = 1'b0;
    frame_good = 1'b0;
    case (state_q)
      IDLE, SHIFT: begin
        if (sin_valid) begin
          shift_load = 1'b1;
          if (count == LAST_IDX) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              state_d    = IDLE;
              frame_done = 1'b1;
              frame_good = 1'b1;
            end
          end else begin
            state_d = SHIFT;
          end
        end
      end
      PARITY: begin
        if (sin_valid) begin
          state_d    = IDLE;
          frame_done = 1'b1;
          frame_good = ~(even_parity(frame_pad) ^ sin);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-edge handshake frees the holding register for the incoming frame.
  always_comb begin
    hold_free = !q_valid_q || q_ready;
    q_d       = q_q;
    q_valid_d = q_valid_q && !q_ready;
    perr_d    = frame_done && !frame_good;
    ovr_d     = ovr_q && !overrun_clr;
    if (frame_done && frame_good) begin
      if (hold_free) begin
        q_d       = frame;
        q_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_deserializer8.sv
// tb/tb_serial_deserializer8.sv - self-checking bench for serial_deserializer8
module tb_serial_deserializer8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sin_v = '0;
  logic [1:0] sv_v = '0;
  logic [1:0] rdy_v = '0;
  logic [1:0] clr_v = '0;
  logic [0:7] q_w [2];
  logic [1:0] qv_w;
  logic [1:0] perr_w;
  logic [1:0] ovr_w;

  int checks = 0;
  int failures = 0;

  // Model state per instance: index 1 has parity enabled, index 0 does not.
  int         m_cnt  [2];
  logic [7:0] m_data [2];
  logic       m_par  [2];
  logic [7:0] m_q    [2];
  logic       m_qv   [2];
  logic       m_perr [2];
  logic       m_ovr  [2];

  always #5 clk = ~clk;

  serial_deserializer8 #(.WIDTH(8), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .sin(sin_v[1]), .sin_valid(sv_v[1]),
    .q(q_w[1]), .q_valid(qv_w[1]), .q_ready(rdy_v[1]),
    .parity_err(perr_w[1]), .overrun(ovr_w[1]), .overrun_clr(clr_v[1])
  );

  serial_deserializer8 #(.WIDTH(8), .PARITY_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .sin(sin_v[0]), .sin_valid(sv_v[0]),
    .q(q_w[0]), .q_valid(qv_w[0]), .q_ready(rdy_v[0]),
    .parity_err(perr_w[0]), .overrun(ovr_w[0]), .overrun_clr(clr_v[0])
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic par_of(input logic [7:0] b);
    return ($countones(b) % 2) != 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_data[k] = '0; m_par[k] = 1'b0; m_q[k] = '0;
      m_qv[k] = 1'b0; m_perr[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one clock on instance i and advance the frame-level model.
  task automatic step(input int i, input logic b, input logic v, input logic r, input logic c);
    int   nb;
    logic done, good, loaded, newovr;
    nb = (i == 1) ? 9 : 8;
    sin_v[i] = b; sv_v[i] = v; rdy_v[i] = r; clr_v[i] = c;
    done = 1'b0; good = 1'b0; loaded = 1'b0; newovr = 1'b0;
    m_perr[i] = 1'b0;
    if (v) begin
      if (m_cnt[i] < 8) m_data[i] = {m_data[i][6:0], b};
      else m_par[i] = b;
      m_cnt[i]++;
      if (m_cnt[i] == nb) begin
        done = 1'b1;
        m_cnt[i] = 0;
        good = (nb == 8) || ((($countones(m_data[i]) + int'(m_par[i])) % 2) == 0);
      end
    end
    if (done && !good) m_perr[i] = 1'b1;
    if (done && good) begin
      if (!m_qv[i] || r) begin m_q[i] = m_data[i]; loaded = 1'b1; end
      else newovr = 1'b1;
    end
    if (loaded) m_qv[i] = 1'b1;
    else if (m_qv[i] && r) m_qv[i] = 1'b0;
    m_ovr[i] = (m_ovr[i] && !c) || newovr;
    @(posedge clk); #1;
    sin_v[i] = 1'b0; sv_v[i] = 1'b0; rdy_v[i] = 1'b0; clr_v[i] = 1'b0;
  endtask

  task automatic send_frame(input int i, input logic [7:0] byt, input logic par,
                            input logic last_rdy, input int gap);
    int nb;
    nb = (i == 1) ? 9 : 8;
    for (int k = 0; k < nb; k++) begin
      step(i, (k < 8) ? byt[7-k] : par, 1'b1, (k == nb - 1) ? last_rdy : 1'b0, 1'b0);
      if (k != nb - 1) for (int g = 0; g < gap; g++) step(i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if (q_w[k] !== 8'h00) begin failures++; $display("FAIL reset_q[%0d] actual=%h expected=00", k, q_w[k]); end
      checks++; if (qv_w[k] !== 1'b0) begin failures++; $display("FAIL reset_q_valid[%0d] actual=%b expected=0", k, qv_w[k]); end
      checks++; if (perr_w[k] !== 1'b0) begin failures++; $display("FAIL reset_parity_err[%0d] actual=%b expected=0", k, perr_w[k]); end
      checks++; if (ovr_w[k] !== 1'b0) begin failures++; $display("FAIL reset_overrun[%0d] actual=%b expected=0", k, ovr_w[k]); end
    end
    for (int k = 0; k < 3; k++) step(1, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    checks++; if (q_w[1] !== 8'h00 || qv_w[1] !== 1'b0 || ovr_w[1] !== 1'b0) begin
      failures++; $display("FAIL midframe_reset actual=q:%h v:%b o:%b expected=q:00 v:0 o:0", q_w[1], qv_w[1], ovr_w[1]);
    end
    send_frame(1, 8'h3C, par_of(8'h3C), 1'b0, 0);
    checks++; if (q_w[1] !== 8'h3C || qv_w[1] !== 1'b1) begin
      failures++; $display("FAIL post_reset_frame actual=q:%h v:%b expected=q:3c v:1", q_w[1], qv_w[1]);
    end
    step(1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_good_frame();
    logic [7:0] b;
    b = 8'hA5;
    for (int k = 0; k < 8; k++) step(1, b[7-k], 1'b1, 1'b0, 1'b0);
    checks++; if (qv_w[1] !== 1'b0) begin failures++; $display("FAIL good_before_parity_valid actual=%b expected=0", qv_w[1]); end
    step(1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (q_w[1] !== 8'hA5) begin failures++; $display("FAIL good_q actual=%h expected=a5", q_w[1]); end
    checks++; if (qv_w[1] !== 1'b1) begin failures++; $display("FAIL good_q_valid actual=%b expected=1", qv_w[1]); end
    step(1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (qv_w[1] !== 1'b0 || q_w[1] !== 8'hA5) begin
      failures++; $display("FAIL consume actual=q:%h v:%b expected=q:a5 v:0", q_w[1], qv_w[1]);
    end
  endtask

  task automatic test_parity_err();
    send_frame(1, 8'h6D, 1'b0, 1'b0, 0);
    checks++; if (perr_w[1] !== 1'b1) begin failures++; $display("FAIL parity_err_pulse actual=%b expected=1", perr_w[1]); end
    checks++; if (q_w[1] !== 8'hA5 || qv_w[1] !== 1'b0) begin
      failures++; $display("FAIL parity_err_hold actual=q:%h v:%b expected=q:a5 v:0", q_w[1], qv_w[1]);
    end
    step(1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (perr_w[1] !== 1'b0) begin failures++; $display("FAIL parity_err_one_cycle actual=%b expected=0", perr_w[1]); end
  endtask

  task automatic test_overrun();
    send_frame(1, 8'h25, par_of(8'h25), 1'b0, 0);
    send_frame(1, 8'h52, par_of(8'h52), 1'b0, 0);
    checks++; if (q_w[1] !== 8'h25 || qv_w[1] !== 1'b1) begin
      failures++; $display("FAIL overrun_q actual=q:%h v:%b expected=q:25 v:1", q_w[1], qv_w[1]);
    end
    checks++; if (ovr_w[1] !== 1'b1) begin failures++; $display("FAIL overrun_set actual=%b expected=1", ovr_w[1]); end
    step(1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ovr_w[1] !== 1'b1) begin failures++; $display("FAIL overrun_sticky actual=%b expected=1", ovr_w[1]); end
    step(1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (ovr_w[1] !== 1'b0) begin failures++; $display("FAIL overrun_clr actual=%b expected=0", ovr_w[1]); end
    step(1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    send_frame(1, 8'hBA, par_of(8'hBA), 1'b0, 0);
    checks++; if (q_w[1] !== 8'hBA || qv_w[1] !== 1'b1) begin
      failures++; $display("FAIL simul_first actual=q:%h v:%b expected=q:ba v:1", q_w[1], qv_w[1]);
    end
    send_frame(1, 8'hC5, par_of(8'hC5), 1'b1, 0);
    checks++; if (q_w[1] !== 8'hC5 || qv_w[1] !== 1'b1 || ovr_w[1] !== 1'b0) begin
      failures++; $display("FAIL simul_replace actual=q:%h v:%b o:%b expected=q:c5 v:1 o:0", q_w[1], qv_w[1], ovr_w[1]);
    end
    step(1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_gapped();
    logic [7:0] b;
    b = 8'h99;
    send_frame(1, b, par_of(b), 1'b0, 2);
    checks++; if (q_w[1] !== 8'h99 || qv_w[1] !== 1'b1) begin
      failures++; $display("FAIL gapped_parity actual=q:%h v:%b expected=q:99 v:1", q_w[1], qv_w[1]);
    end
    step(1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(0, b[7-k], 1'b1, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (qv_w[0] !== 1'b0) begin failures++; $display("FAIL noparity_early_valid actual=%b expected=0", qv_w[0]); end
    step(0, b[0], 1'b1, 1'b0, 1'b0);
    checks++; if (q_w[0] !== 8'h99 || qv_w[0] !== 1'b1) begin
      failures++; $display("FAIL noparity_frame actual=q:%h v:%b expected=q:99 v:1", q_w[0], qv_w[0]);
    end
    step(0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic b, v, r, c;
    for (int i = 1; i >= 0; i--) begin
      for (int n = 0; n < 400; n++) begin
        b = 1'($urandom_range(0, 1));
        v = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
        c = ($urandom_range(0, 19) == 0);
        step(i, b, v, r, c);
        checks++; if (q_w[i] !== m_q[i]) begin failures++; $display("FAIL rand_q[%0d] n=%0d actual=%h expected=%h", i, n, q_w[i], m_q[i]); end
        checks++; if (qv_w[i] !== m_qv[i]) begin failures++; $display("FAIL rand_q_valid[%0d] n=%0d actual=%b expected=%b", i, n, qv_w[i], m_qv[i]); end
        checks++; if (perr_w[i] !== m_perr[i]) begin failures++; $display("FAIL rand_parity_err[%0d] n=%0d actual=%b expected=%b", i, n, perr_w[i], m_perr[i]); end
        checks++; if (ovr_w[i] !== m_ovr[i]) begin failures++; $display("FAIL rand_overrun[%0d] n=%0d actual=%b expected=%b", i, n, ovr_w[i], m_ovr[i]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_parity_err();
    test_overrun();
    test_simultaneous();
    test_gapped();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer8.md
# serial_deserializer8

Serial-in, parallel-out front end that assembles a bit stream into bytes and hands each completed byte, with a valid/ready handshake, to the 8-bit data register stage. An optional even-parity bit follows each byte. A one-entry holding register decouples bit collection from consumption, so the next byte can shift in while the current one waits. Overrun and parity errors are flagged instead of corrupting held data.

## Interface
Parameters:
- WIDTH, 8, data bits per frame.
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity phase.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only on edges where this is 1.
- q  output  [0:WIDTH-1]  held byte; first received bit lands in q[0].
- q_valid  output  1  q holds an unconsumed byte.
- q_ready  input  1  downstream accepts q on an edge where q_valid && q_ready.
- parity_err  output  1  one-cycle pulse; a frame was discarded for bad parity.
- overrun  output  1  sticky; a good frame was dropped because the holding register was full.
- overrun_clr  input  1  clears overrun on the next edge.

## Operation
- Reset (rst=1 at an edge): state IDLE, bit count 0, shift register 0, q=0, q_valid=0, parity_err=0, overrun=0. Reset dominates all other inputs. Reset mid-frame discards the partial frame.
- FSM states:
  - IDLE: the first sin_valid bit is stored as bit 0; go to SHIFT with count=1.
  - SHIFT: each sin_valid bit is stored at index count and count increments. When bit WIDTH-1 is stored, go to PARITY if PARITY_EN, else complete the frame and return to IDLE.
  - PARITY: the next sin_valid bit is the parity bit. Frame is good if the XOR of the data bits and the parity bit is 0. Frame completes; return to IDLE.
- Edges with sin_valid=0 hold state, count and shift contents unchanged. Gaps between bits are unlimited.
- Frame completion:
  - Bad parity: discard the byte, pulse parity_err for one cycle, leave q/q_valid unchanged.
  - Good frame, holding register free: load q and set q_valid. "Free" means q_valid=0, or q_valid && q_ready on the same edge.
  - Good frame, holding register not free: drop the byte, set overrun, leave q unchanged.
- Consumption: q_valid && q_ready clears q_valid. q keeps its last value; it is not zeroed.
- overrun_clr and a new overrun on the same edge: overrun stays 1.
- Count is the narrowest width holding 0..WIDTH-1. There is no wrap beyond the frame; each frame restarts at index 0.

## Timing
- Bits are sampled on the rising edge where sin_valid=1. Back-to-back bits are allowed on every cycle.
- Latency: q and q_valid update on the same edge that samples the final bit of the frame (last data bit, or parity bit when PARITY_EN=1). parity_err asserts on that same edge.
- Throughput: one frame per WIDTH(+1) sin_valid cycles. A new frame may start on the edge right after completion.
- q is stable while q_valid=1 and no handshake has occurred.
- Simultaneous completion and handshake on one edge: q loads the new byte, q_valid stays 1, no overrun.

## Structure
- Package serial_deserializer8_pkg holds:
  - state enum (IDLE, SHIFT, PARITY)
  - default WIDTH constant
  - function computing even parity over a WIDTH vector
- Sub-module sipo_shift_reg: WIDTH-bit indexed bit-insert register with count, clk/rst/load-enable. The top level holds the FSM, holding register and flags.

## Test plan
- Reset: assert rst for 1 edge mid-frame after 3 bits -> q=8'h00, q_valid=0, overrun=0. The next 8 bits+parity form a clean frame.
- Good frame: send bits 1,0,1,0,0,1,0,1 with parity 0 back-to-back, q_ready=0 -> q=8'hA5, q_valid=1 on the parity-bit edge. Assert q_ready -> q_valid=0, q stays 8'hA5.
- Parity error: send 8'h6D with parity 0 -> parity_err high exactly one cycle, q/q_valid unchanged.
- Overrun: hold q_ready=0, send 8'h25 then 8'h52 -> q=8'h25, overrun=1. Pulse overrun_clr -> overrun=0.
- Simultaneous: q_valid=1 with 8'hBA, assert q_ready on the completion edge of 8'hC5 -> q=8'hC5, q_valid=1, overrun=0.
- Gapped input: send 8'h99 with sin_valid low for 2 cycles between every bit -> q=8'h99. PARITY_EN=0 build: same byte completes on the 8th bit edge.
